// File: rtl/i2c_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_cfg_pkg
// Brief    : Shared types for the I2C configuration-write arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package i2c_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  typedef struct packed {
    logic [7:0] slave;
    logic [7:0] sub;
    logic [7:0] data;
  } xfer_t;

  // 7-bit address 0x1A with the write bit appended
  localparam logic [7:0] c_WM8731_ADDR = 8'h34;

endpackage
`default_nettype wire

// File: rtl/i2c_cfg_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : i2c_cfg_arb_rr_pick
// Brief    : Combinational round-robin picker: first set request at or above
//            the pointer, wrapping around.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_cfg_arb_rr_pick #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic          o_valid,
  output logic [N-1:0]  o_onehot,
  output logic [PW-1:0] o_idx
);

  int w_dist;
  int w_best;

  // Smallest circular distance from the pointer wins
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    w_dist   = 0;
    w_best   = N;
    for (int k = 0; k < N; k++) begin
      if (i_req[k]) begin
        w_dist = (k >= int'(i_ptr)) ? (k - int'(i_ptr)) : (k + N - int'(i_ptr));
        if (w_dist < w_best) begin
          w_best      = w_dist;
          o_onehot    = '0;
          o_onehot[k] = 1'b1;
          o_idx       = PW'(k);
        end
      end
    end
  end

  assign o_valid = |i_req;

endmodule
`default_nettype wire

// File: rtl/i2c_cfg_arb.sv
`default_nettype none
// ============================================================================
// Module   : i2c_cfg_arb
// Brief    : Round-robin arbiter sharing one I2C write engine, with retry on
//            NACK/timeout and an enforced bus-idle gap between transfers.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_cfg_arb
  import i2c_cfg_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int RETRY_MAX = 3,
  parameter int TIMEOUT   = 1023,
  parameter int GAP       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_cen,
  input  logic [NREQ-1:0]    i_req,
  input  logic [24*NREQ-1:0] i_req_data,
  output logic [NREQ-1:0]    o_gnt,
  output logic [NREQ-1:0]    o_done,
  output logic [NREQ-1:0]    o_err,
  output logic               o_busy,
  output logic [23:0]        o_i2c_data,
  output logic               o_i2c_go,
  input  logic               i_i2c_end,
  input  logic               i_i2c_nack
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [TW-1:0] c_TIMEOUT   = TW'(TIMEOUT);
  localparam logic [3:0]    c_RETRY_MAX = 4'(RETRY_MAX);
  localparam logic [7:0]    c_GAP_LAST  = 8'(GAP - 1);
  localparam logic [PW-1:0] c_LAST_IDX  = PW'(NREQ - 1);

  state_t          r_state;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_idx;
  logic [3:0]      r_retry;
  logic [TW-1:0]   r_timer;
  logic [7:0]      r_gap_cnt;
  logic            r_fail;
  logic            r_retry_pend;
  xfer_t           r_xfer;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_done;
  logic [NREQ-1:0] r_err;
  logic            r_busy;
  logic            r_go;

  logic            w_pick_valid;
  logic [NREQ-1:0] w_pick_onehot;
  logic [PW-1:0]   w_pick_idx;
  logic [23:0]     w_req_word [NREQ];
  logic [TW-1:0]   w_timer_inc;
  logic [PW-1:0]   w_ptr_next;

  generate
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign w_req_word[g] = i_req_data[24*g +: 24];
    end
  endgenerate

  i2c_cfg_arb_rr_pick #(
    .N  (NREQ),
    .PW (PW)
  ) u_pick (
    .i_req    (i_req),
    .i_ptr    (r_ptr),
    .o_valid  (w_pick_valid),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx)
  );

  assign w_timer_inc = r_timer + TW'(1);
  assign w_ptr_next  = (r_idx == c_LAST_IDX) ? '0 : r_idx + PW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_ptr        <= '0;
      r_idx        <= '0;
      r_retry      <= '0;
      r_timer      <= '0;
      r_gap_cnt    <= '0;
      r_fail       <= 1'b0;
      r_retry_pend <= 1'b0;
      r_xfer       <= '0;
      r_gnt        <= '0;
      r_done       <= '0;
      r_err        <= '0;
      r_busy       <= 1'b0;
      r_go         <= 1'b0;
    end else begin
      // Completion pulses last one clk even when cen is sparse
      r_done <= '0;
      r_err  <= '0;
      if (i_cen) begin
        case (r_state)
          ST_IDLE: begin
            if (w_pick_valid) begin
              r_idx   <= w_pick_idx;
              r_gnt   <= w_pick_onehot;
              r_xfer  <= xfer_t'(w_req_word[w_pick_idx]);
              r_retry <= '0;
              r_busy  <= 1'b1;
              r_state <= ST_ISSUE;
            end
          end
          ST_ISSUE: begin
            r_go    <= 1'b1;
            r_timer <= '0;
            r_state <= ST_WAIT;
          end
          ST_WAIT: begin
            r_timer <= w_timer_inc;
            if (i_i2c_end) begin
              r_go    <= 1'b0;
              r_fail  <= i_i2c_nack;
              r_state <= ST_CHECK;
            end else if (w_timer_inc == c_TIMEOUT) begin
              r_go    <= 1'b0;
              r_fail  <= 1'b1;
              r_state <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            r_gap_cnt <= '0;
            r_state   <= ST_GAP;
            if (!r_fail) begin
              r_done       <= r_gnt;
              r_gnt        <= '0;
              r_ptr        <= w_ptr_next;
              r_retry_pend <= 1'b0;
            end else if (r_retry < c_RETRY_MAX) begin
              r_retry      <= r_retry + 4'd1;
              r_retry_pend <= 1'b1;
            end else begin
              r_err        <= r_gnt;
              r_gnt        <= '0;
              r_ptr        <= w_ptr_next;
              r_retry_pend <= 1'b0;
            end
          end
          ST_GAP: begin
            if (r_gap_cnt == c_GAP_LAST) begin
              if (r_retry_pend) begin
                r_state <= ST_ISSUE;
              end else begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_gap_cnt <= r_gap_cnt + 8'd1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_gnt      = r_gnt;
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_busy     = r_busy;
  assign o_i2c_data = r_xfer;
  assign o_i2c_go   = r_go;

endmodule
`default_nettype wire
